serial_tc_decoder: RTL and testbench
====================================

Name: serial_tc_decoder

Overview:
Receive-side counterpart of the team's bit-serial two's-complementer. Takes an LSB-first serial stream of two's-complemented words, re-applies the serial complement rule bit-by-bit to recover the original value, and assembles each word into a parallel output. Output is presented through a one-entry valid/ready buffer with overrun and framing error reporting.

Parameters:
WIDTH, 8, bits per serial word (legal range 2..32)

Ports:
t_clock  input  1  system clock; all state updates on rising edge
r_n  input  1  reset, asynchronous assert, active-low; the only reset
x  input  1  serial data bit, LSB first
x_valid  input  1  x carries a bit this cycle
x_first  input  1  qualifies x as bit 0 (LSB) of a new frame; ignored unless x_valid
dout  output  WIDTH  decoded word
dout_valid  output  1  dout holds an unconsumed word
dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready
dout_ovf  output  1  held word decoded to 2^(WIDTH-1), the most-negative value, which has no positive counterpart
sync_err  output  1  one-cycle pulse when a frame is aborted by an early x_first
overrun  output  1  sticky; a completed word was dropped because the buffer was full

Behaviour:
- Reset (r_n=0, async): state=HUNT, bit counter=0, seen_one=0, shift register=0, dout=0, dout_valid=0, dout_ovf=0, sync_err=0, overrun=0. Asserting reset mid-frame discards the partial word. Asserting it with a word buffered discards that word.
- FSM states: HUNT and COLLECT.
- HUNT:
  - x_valid && !x_first: bit ignored.
  - x_valid && x_first: bit processed as bit 0, counter=1, go to COLLECT.
- Bit processing (bit k):
  - decoded y = x XOR seen_one, where seen_one is the value before this bit.
  - Then seen_one |= x. The bit-0 update starts from seen_one=0.
  - Shift register shifts right with y inserted at the MSB. After WIDTH bits, bit 0 sits at the LSB.
- COLLECT:
  - x_valid && !x_first: process the bit and increment the counter.
  - x_valid && x_first: abort the partial frame, pulse sync_err for 1 cycle, and restart with this bit as bit 0 (counter=1). Remain in COLLECT.
  - !x_valid: hold all state. Gaps of any length are legal.
- Frame completion (bit WIDTH-1 processed):
  - The word is complete; return to HUNT and reset counter and seen_one.
  - If the buffer is free, load dout with the full word (including the final bit). Set dout_ovf = (word == 1 followed by WIDTH-1 zeros).
  - Buffer free means !dout_valid, or dout_valid && dout_ready in the same cycle.
  - dout_valid rises the cycle after the edge that sampled the final bit: 1-cycle latency from the last bit.
  - If the buffer is full and not draining: drop the new word, set overrun (sticky until reset), and leave the buffer contents untouched.
  - WIDTH=1 frames do not exist. When WIDTH=2, x_first on bit 1 is an abort, not a completion.
- Handshake:
  - dout, dout_ovf stable while dout_valid && !dout_ready.
  - On acceptance with no simultaneous load, dout_valid=0 next cycle. dout and dout_ovf may hold their stale value.
- Zero word: all-zero input decodes to 0, seen_one never sets, dout_ovf=0.
- Arithmetic: purely bitwise, no adders. The counter is ceil(log2(WIDTH+1)) bits and never wraps past WIDTH-1.

Decomposition:
- Shared package (serial_tc_pkg): FSM state enum (HUNT, COLLECT), function computing the counter width from WIDTH, and a MOST_NEG constant function (1 followed by WIDTH-1 zeros).
- One natural sub-module: tc_out_buffer. It is the one-entry valid/ready holding register with the free/overrun decision, and is reusable by the future transmit side.

Test Plan:
(all with WIDTH=8, bits listed LSB first)
1. Decode 0xFB: x_first on bit 0, bits 1,1,0,1,1,1,1,1, dout_ready=1 -> dout=0x05, dout_valid high 1 cycle after bit 7, dout_ovf=0.
2. Boundary values: stream 0x80 (0,0,0,0,0,0,0,1) -> dout=0x80, dout_ovf=1. Stream 0x00 -> dout=0x00, dout_ovf=0. Stream 0xFF -> dout=0x01.
3. Gaps and backpressure: 0xFB sent with random x_valid gaps, then 0x01 sent while dout_ready=0 -> first word held stable as 0x05, second word (0xFF) dropped, overrun=1 and sticky. Then raise dout_ready and send 0x01 simultaneously with the drain cycle -> dout=0xFF, no additional overrun.
4. Resync: 3 bits of a frame, then x_first with a new full frame of 0xFE -> sync_err pulses exactly 1 cycle, dout=0x02. The partial frame is never output.
5. Reset mid-operation: r_n low asynchronously between edges after bit 4, and again while dout_valid=1 -> all outputs 0 immediately, FSM in HUNT. A subsequent bit without x_first is ignored.
6. Stray bits in HUNT: x_valid=1, x_first=0 for 5 cycles, then a full frame 0xFB -> only dout=0x05 produced, sync_err stays 0.

Source files
------------

// File: rtl/serial_tc_pkg.sv
// Shared types and elaboration helpers for the serial two's-complement datapath.
// No latency or backpressure of its own; constants only.
package serial_tc_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Bit counter must hold 0..WIDTH without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Most-negative word: 1 followed by width-1 zeros.
  function automatic logic [31:0] most_neg(input int width);
    return 32'h1 << (width - 1);
  endfunction

endpackage

// File: rtl/serial_tc_decoder_if.sv
// Serial-in / parallel-out bundle for the two's-complement decoder.
// Master drives the serial stream and dout_ready; slave returns the decoded word and status.
interface serial_tc_decoder_if #(
  parameter int WIDTH = 8
);

  logic             x;
  logic             x_valid;
  logic             x_first;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_ovf;
  logic             sync_err;
  logic             overrun;

  modport master (
    output x, x_valid, x_first, dout_ready,
    input  dout, dout_valid, dout_ovf, sync_err, overrun
  );

  modport slave (
    input  x, x_valid, x_first, dout_ready,
    output dout, dout_valid, dout_ovf, sync_err, overrun
  );

endinterface

// File: rtl/tc_out_buffer.sv
// One-entry valid/ready holding register for parallel words.
// Loads on the cycle after load_vld; a load while full and not draining is dropped and flags sticky overrun.
module tc_out_buffer #(
  parameter int DW = 9
) (
  input  logic          core_clk,
  input  logic          arst_n,
  input  logic          load_vld,
  input  logic [DW-1:0] load_dat,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_dat,
  output logic          overrun
);

  logic free;

  // A same-cycle drain frees the slot for an incoming word.
  assign free = !out_vld || out_rdy;

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      out_vld <= 1'b0;
      out_dat <= '0;
      overrun <= 1'b0;
    end else begin
      if (load_vld && free) begin
        out_vld <= 1'b1;
        out_dat <= load_dat;
      end else if (load_vld) begin
        overrun <= 1'b1;
      end else if (out_rdy) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_tc_decoder.sv
// LSB-first serial two's-complement decoder with parallel valid/ready output.
// Word valid one cycle after its last bit is sampled; full buffer drops new words and sets overrun.
module serial_tc_decoder
  import serial_tc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                t_clock,
  input logic                r_n,
  serial_tc_decoder_if.slave tc
);

  localparam int               CW       = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             seen_one;
  logic [WIDTH-1:0] sreg;
  logic             sync_err_q;

  logic [WIDTH-1:0] sreg_first;
  logic [WIDTH-1:0] sreg_nxt;
  logic             last_bit;
  logic [WIDTH:0]   buf_in;
  logic [WIDTH:0]   buf_out;

  // Bit 0 always starts from seen_one=0, so it passes through undecoded.
  assign sreg_first = {tc.x, sreg[WIDTH-1:1]};
  assign sreg_nxt   = {tc.x ^ seen_one, sreg[WIDTH-1:1]};

  assign last_bit = tc.x_valid && !tc.x_first && (state == COLLECT)
                    && (cnt == CW'(WIDTH - 1));

  assign buf_in = {sreg_nxt == MOST_NEG, sreg_nxt};

  always_ff @(posedge t_clock or negedge r_n) begin
    if (!r_n) begin
      state      <= HUNT;
      cnt        <= '0;
      seen_one   <= 1'b0;
      sreg       <= '0;
      sync_err_q <= 1'b0;
    end else begin
      sync_err_q <= 1'b0;
      if (tc.x_valid) begin
        if (tc.x_first) begin
          // Early x_first aborts any partial frame and restarts on this bit.
          sync_err_q <= (state == COLLECT);
          state      <= COLLECT;
          cnt        <= CW'(1);
          seen_one   <= tc.x;
          sreg       <= sreg_first;
        end else if (state == COLLECT) begin
          sreg <= sreg_nxt;
          if (last_bit) begin
            state    <= HUNT;
            cnt      <= '0;
            seen_one <= 1'b0;
          end else begin
            cnt      <= cnt + CW'(1);
            seen_one <= seen_one | tc.x;
          end
        end
      end
    end
  end

  tc_out_buffer #(
    .DW(WIDTH + 1)
  ) u_out_buffer (
    .core_clk (t_clock),
    .arst_n   (r_n),
    .load_vld (last_bit),
    .load_dat (buf_in),
    .out_vld  (tc.dout_valid),
    .out_rdy  (tc.dout_ready),
    .out_dat  (buf_out),
    .overrun  (tc.overrun)
  );

  assign tc.dout     = buf_out[WIDTH-1:0];
  assign tc.dout_ovf = buf_out[WIDTH];
  assign tc.sync_err = sync_err_q;

endmodule

// File: tb/tb_serial_tc_decoder.sv
// Scoreboard bench for serial_tc_decoder: directed cases plus randomized frames,
// expected words derived as the arithmetic negation of each transmitted word.
module tb_serial_tc_decoder;

  localparam int W = 8;

  logic t_clock = 1'b0;
  logic r_n;

  serial_tc_decoder_if #(.WIDTH(W)) tc ();

  serial_tc_decoder #(.WIDTH(W)) dut (
    .t_clock (t_clock),
    .r_n     (r_n),
    .tc      (tc.slave)
  );

  always #5 t_clock = ~t_clock;

  typedef struct {
    logic [W-1:0] w;
    logic         o;
  } exp_t;

  exp_t         exp_q[$];
  int           checks    = 0;
  int           failures  = 0;
  int           sync_seen = 0;
  int           exp_sync  = 0;
  bit           rand_ready = 1'b0;
  logic [W-1:0] enc;
  int           mode;
  int           k;
  int           n;

  // Sender transmits -v; the decoder must return v = 2^W - sent (mod 2^W).
  function automatic exp_t decode_model(input logic [W-1:0] sent);
    exp_t e;
    int   v;
    v   = (1 << W) - int'(sent);
    e.w = v[W-1:0];
    e.o = (e.w == W'(1 << (W - 1)));
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge t_clock);
    #1;
  endtask

  task automatic set_ready(input bit force_rdy);
    if (force_rdy) tc.dout_ready = 1'b1;
    else if (rand_ready) tc.dout_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle();
    set_ready(1'b0);
    tc.x_valid = 1'b0;
    tc.x_first = 1'b0;
    tick();
  endtask

  task automatic settle(input int cycles);
    repeat (cycles) idle();
  endtask

  task automatic send_bit(input logic b, input logic first, input bit force_rdy);
    set_ready(force_rdy);
    tc.x       = b;
    tc.x_valid = 1'b1;
    tc.x_first = first;
    tick();
    tc.x_valid = 1'b0;
    tc.x_first = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] word, input int gap_max, input bit push,
                            input bit rdy_last);
    for (int i = 0; i < W; i++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (g) idle();
      if (i == W - 1 && push) exp_q.push_back(decode_model(word));
      send_bit(word[i], (i == 0), (i == W - 1) && rdy_last);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dout_valid"}, 32'(tc.dout_valid), 32'd0);
    chk({tag, "_dout"},       32'(tc.dout),       32'd0);
    chk({tag, "_dout_ovf"},   32'(tc.dout_ovf),   32'd0);
    chk({tag, "_sync_err"},   32'(tc.sync_err),   32'd0);
    chk({tag, "_overrun"},    32'(tc.overrun),    32'd0);
  endtask

  // Monitor: compare every presented word against the scoreboard head.
  always @(negedge t_clock) begin
    if (r_n === 1'b1) begin
      if (tc.sync_err === 1'b1) sync_seen++;
      if (tc.dout_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word: got dout=%0h, required no pending word", tc.dout);
        end else begin
          if (tc.dout !== exp_q[0].w || tc.dout_ovf !== exp_q[0].o) begin
            failures++;
            $display("FAIL scoreboard: got dout=%0h ovf=%0b required dout=%0h ovf=%0b",
                     tc.dout, tc.dout_ovf, exp_q[0].w, exp_q[0].o);
          end
          if (tc.dout_ready === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    r_n           = 1'b0;
    tc.x          = 1'b0;
    tc.x_valid    = 1'b0;
    tc.x_first    = 1'b0;
    tc.dout_ready = 1'b1;
    #3;
    chk_all_zero("reset");
    @(posedge t_clock);
    #1;
    r_n = 1'b1;
    tick();

    // Decode 0xFB with exact one-cycle latency from the last bit.
    enc = 8'hFB;
    for (int i = 0; i < W - 1; i++) send_bit(enc[i], (i == 0), 1'b0);
    exp_q.push_back(decode_model(enc));
    tc.x       = enc[W-1];
    tc.x_valid = 1'b1;
    tc.x_first = 1'b0;
    @(negedge t_clock);
    chk("t1_valid_before_last", 32'(tc.dout_valid), 32'd0);
    @(posedge t_clock);
    #1;
    tc.x_valid = 1'b0;
    chk("t1_valid_after_last", 32'(tc.dout_valid), 32'd1);
    chk("t1_dout", 32'(tc.dout), 32'h05);
    chk("t1_ovf", 32'(tc.dout_ovf), 32'd0);
    settle(2);

    // Boundary words.
    send_frame(8'h80, 0, 1'b1, 1'b0);
    chk("t2_ovf_most_neg", 32'(tc.dout_ovf), 32'd1);
    chk("t2_dout_most_neg", 32'(tc.dout), 32'h80);
    send_frame(8'h00, 0, 1'b1, 1'b0);
    send_frame(8'hFF, 0, 1'b1, 1'b0);
    settle(2);

    // Gaps and backpressure: hold, drop with overrun, then load during drain.
    tc.dout_ready = 1'b0;
    send_frame(8'hFB, 3, 1'b1, 1'b0);
    settle(3);
    chk("t3_held_valid", 32'(tc.dout_valid), 32'd1);
    chk("t3_held_dout", 32'(tc.dout), 32'h05);
    chk("t3_no_overrun_yet", 32'(tc.overrun), 32'd0);
    send_frame(8'h01, 2, 1'b0, 1'b0);
    settle(2);
    chk("t3_overrun_set", 32'(tc.overrun), 32'd1);
    chk("t3_still_first", 32'(tc.dout), 32'h05);
    send_frame(8'h01, 0, 1'b1, 1'b1);
    settle(3);
    chk("t3_overrun_sticky", 32'(tc.overrun), 32'd1);
    chk("t3_drained", 32'(tc.dout_valid), 32'd0);

    // Resync on early x_first.
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    exp_sync++;
    send_frame(8'hFE, 0, 1'b1, 1'b0);
    settle(2);
    chk("t4_sync_pulses", 32'(sync_seen), 32'(exp_sync));

    // Stray bits while hunting are ignored.
    repeat (5) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    send_frame(8'hFB, 0, 1'b1, 1'b0);
    settle(2);
    chk("t6_sync_pulses", 32'(sync_seen), 32'(exp_sync));

    // Async reset mid-frame.
    enc = 8'hFB;
    for (int i = 0; i < 5; i++) send_bit(enc[i], (i == 0), 1'b0);
    #2;
    r_n = 1'b0;
    exp_q.delete();
    #1;
    chk_all_zero("t5_mid_frame");
    @(posedge t_clock);
    #1;
    r_n = 1'b1;
    send_bit(1'b1, 1'b0, 1'b0);
    settle(1);
    send_frame(8'hFB, 0, 1'b1, 1'b0);
    settle(2);
    chk("t5_sync_pulses", 32'(sync_seen), 32'(exp_sync));

    // Async reset with a word buffered.
    tc.dout_ready = 1'b0;
    send_frame(8'h80, 0, 1'b1, 1'b0);
    settle(1);
    chk("t5_buffered_valid", 32'(tc.dout_valid), 32'd1);
    chk("t5_buffered_ovf", 32'(tc.dout_ovf), 32'd1);
    #2;
    r_n = 1'b0;
    exp_q.delete();
    #1;
    chk_all_zero("t5_buffered");
    @(posedge t_clock);
    #1;
    r_n           = 1'b1;
    tc.dout_ready = 1'b1;
    settle(1);

    // Randomized frames, gaps, stray bits, aborts and consumer stalls.
    rand_ready = 1'b1;
    repeat (40) begin
      mode = int'($urandom_range(0, 3));
      if (mode == 1) begin
        repeat ($urandom_range(1, 4)) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end else if (mode == 2) begin
        k = int'($urandom_range(1, W - 1));
        for (int j = 0; j < k; j++) send_bit(1'($urandom_range(0, 1)), (j == 0), 1'b0);
        exp_sync++;
      end
      send_frame(8'($urandom), 2, 1'b1, 1'b1);
    end
    rand_ready    = 1'b0;
    tc.dout_ready = 1'b1;
    settle(3);
    chk("rand_sync_pulses", 32'(sync_seen), 32'(exp_sync));
    chk("rand_no_overrun", 32'(tc.overrun), 32'd0);

    n = 0;
    while ((exp_q.size() != 0 || tc.dout_valid === 1'b1) && n < 50) begin
      idle();
      n++;
    end
    chk("final_pending_words", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
